// File: rtl/fft8_bitrev_input_loader.sv
// Input loader for the 8-point radix-2 FFT: gathers one complex sample per cycle
// into bit-reversed slots and presents the whole frame in parallel to stage 1.
module fft8_bitrev_input_loader #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   IN_Real,
  input  logic [DATA_WIDTH-1:0]   IN_Img,
  input  logic                    IN_Valid,
  input  logic                    IN_Sop,
  output logic                    IN_Ready,
  output logic [8*DATA_WIDTH-1:0] OUT_Real,
  output logic [8*DATA_WIDTH-1:0] OUT_Img,
  output logic                    OUT_Valid,
  input  logic                    OUT_Ready,
  output logic [7:0]              W8_Index,
  output logic                    ERR_Sync
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [2:0]            cnt;
  logic [2:0]            cnt_next;
  logic                  err_q;
  logic                  err_next;
  logic                  wr_en;
  logic [2:0]            wr_slot;
  logic                  accept;
  logic [DATA_WIDTH-1:0] slot_re [8];
  logic [DATA_WIDTH-1:0] slot_im [8];

  function automatic logic [2:0] bitrev3(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

  assign accept = IN_Valid && IN_Ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= FILL;
      cnt   <= 3'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      err_q <= err_next;
    end
  end

  // An early SOP restarts the frame at slot 0 and flags the abort one cycle later;
  // non-SOP samples before any SOP are dropped because cnt stays at 0.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    err_next   = 1'b0;
    wr_en      = 1'b0;
    wr_slot    = 3'd0;
    case (state)
      FILL: begin
        if (accept) begin
          if (IN_Sop) begin
            wr_en    = 1'b1;
            wr_slot  = 3'd0;
            cnt_next = 3'd1;
            err_next = (cnt != 3'd0);
          end else if (cnt != 3'd0) begin
            wr_en   = 1'b1;
            wr_slot = bitrev3(cnt);
            if (cnt == 3'd7) begin
              state_next = FULL;
              cnt_next   = 3'd0;
            end else begin
              cnt_next = cnt + 3'd1;
            end
          end
        end
      end
      FULL: begin
        if (OUT_Ready) begin
          state_next = FILL;
        end
      end
      default: begin
        state_next = FILL;
        cnt_next   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < 8; k++) begin
        slot_re[k] <= '0;
        slot_im[k] <= '0;
      end
    end else if (wr_en) begin
      slot_re[wr_slot] <= IN_Real;
      slot_im[wr_slot] <= IN_Img;
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_out
    assign OUT_Real[k*DATA_WIDTH +: DATA_WIDTH] = slot_re[k];
    assign OUT_Img[k*DATA_WIDTH +: DATA_WIDTH]  = slot_im[k];
  end

  assign IN_Ready  = (state == FILL);
  assign OUT_Valid = (state == FULL);
  assign ERR_Sync  = err_q;
  assign W8_Index  = 8'd0;

endmodule
